muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//   Iterative multiply/divide sequencer that owns the HI/LO register pair of the 5-stage pipeline.
//   Accepts MULT/MULTU/DIV/DIVU from Execute, runs a radix-2 shift/add or shift/subtract loop and writes HI/LO.
//   Raises MdStall, which the hazard detect unit ORs into its stall, whenever Decode touches HI/LO or issues another
//   mul/div while busy. Sits beside the ALU in E; HI/LO read data is muxed into the E-stage result for MFHI/MFLO.
// PARAMETERS
//   WIDTH  32  operand width; HI and LO are WIDTH bits each; iteration count = WIDTH
// PORTS
//   clk        in   1      pipeline clock
//   rst_n      in   1      asynchronous active-low reset
//   StartE     in   1      valid mul/div op in E; accepted only when state==IDLE and !MdStall
//   OpE        in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   SrcAE      in   WIDTH  rs operand (multiplicand / dividend)
//   SrcBE      in   WIDTH  rt operand (multiplier / divisor)
//   HiLoUseD   in   1      D-stage instr is MFHI/MFLO/MTHI/MTLO
//   MdOpD      in   1      D-stage instr is a mul/div
//   HiWrW      in   1      MTHI write in W
//   LoWrW      in   1      MTLO write in W
//   WdW        in   WIDTH  MTHI/MTLO write data
//   Hi         out  WIDTH  HI register
//   Lo         out  WIDTH  LO register
//   MdBusy     out  1      state != IDLE
//   MdStall    out  1      MdBusy && (HiLoUseD || MdOpD)
//   MdDone     out  1      one-cycle pulse in the cycle HI/LO are written by the sequencer
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, count=0, Hi=Lo=0, MdBusy=MdStall=MdDone=0; an in-flight op is discarded.
//   FSM: IDLE -> RUN on accepted StartE; RUN -> FIX when count==0; FIX -> IDLE unconditionally.
//   Accept cycle: latch op; signed ops latch |SrcAE|,|SrcBE| plus result-sign flags; count=WIDTH-1.
//   MUL in RUN: 2*WIDTH-bit {acc,mplier} shift-add, one multiplier bit per cycle, LSB first.
//   DIV in RUN: restoring division, one quotient bit per cycle; remainder WIDTH+1 bits internally.
//   FIX (1 cycle): apply sign; product sign = sA^sB; quotient sign = sA^sB; remainder sign = sA.
//     MUL: Hi=product[2W-1:W], Lo=product[W-1:0]. DIV: Lo=quotient, Hi=remainder. MdDone=1.
//   Latency: accept at cycle 0, RUN cycles 1..WIDTH, FIX at WIDTH+1, new Hi/Lo visible at cycle WIDTH+2.
//   Divide by zero: no trap; Lo=all ones, Hi=dividend (original signed value); same latency.
//   Signed overflow (-2^(W-1) / -1): Lo=-2^(W-1), Hi=0; no exception.
//   Abs of most-negative value: WIDTH-bit unsigned magnitude 2^(W-1), handled without overflow.
//   MTHI/MTLO: HiWrW/LoWrW write Hi/Lo at any state; if coincident with FIX, the W write wins for that register.
//   MdStall guarantees no MTHI/MTLO is issued behind a busy op; a W write while RUN is legal but corrupts nothing
//     (the result overwrites it at FIX).
//   StartE while busy: ignored; upstream must not present it (MdStall holds it in D).
// CONFIGURATION
//   MULDIV_FAST_MUL_EN defined: MULT/MULTU use a single-cycle combinational WIDTHxWIDTH product; FSM goes
//     IDLE -> FIX directly; Hi/Lo visible at cycle 2. DIV unchanged.
//   Undefined: iterative multiply as above (WIDTH+2 cycles). Port list identical in both builds.
// STRUCTURE
//   muldiv_pkg: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), state encodings (ST_IDLE, ST_RUN, ST_FIX),
//     DIV0_LO constant.
//   Sub-module muldiv_signfix: combinational abs-in / negate-out helper, instantiated for operands and results.
//   FSM, counter, accumulator and Hi/Lo registers stay in muldiv_sequencer.
// TESTING
//   MULT 0xFFFFFFFE * 0x00000003 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFA, MdDone at cycle 33 (WIDTH=32).
//   MULTU 0xFFFFFFFF * 0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001; MdBusy high cycles 1..33.
//   DIV -7 / 2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIVU 7 / 0 -> Lo=0xFFFFFFFF, Hi=7.
//   DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0; MFLO in D during RUN -> MdStall=1 until IDLE.
//   rst_n low at RUN cycle 10 -> next cycle MdBusy=0, Hi=Lo=0, no MdDone; the following MULTU 3*5 gives Lo=15.
//   LoWrW=1, WdW=0x1234 coincident with FIX -> Lo=0x1234, Hi=sequencer result; with MULDIV_FAST_MUL_EN MULT 3*4 -> Lo=12 at cycle 2.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencer: operation codes,
// FSM state encodings and the divide-by-zero LO value.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } md_state_e;

  // LO after a divide by zero: all ones, sliced to the operand width by users.
  localparam logic [63:0] DIV0_LO = '1;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Execute/Decode/Writeback-side signals of the multiply/divide sequencer.
// master = pipeline side that drives requests, slave = the sequencer.
interface muldiv_sequencer_if #(parameter int WIDTH = 32);

  logic             StartE;
  logic [1:0]       OpE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic             HiLoUseD;
  logic             MdOpD;
  logic             HiWrW;
  logic             LoWrW;
  logic [WIDTH-1:0] WdW;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             MdBusy;
  logic             MdStall;
  logic             MdDone;

  modport master (
    output StartE, OpE, SrcAE, SrcBE, HiLoUseD, MdOpD, HiWrW, LoWrW, WdW,
    input  Hi, Lo, MdBusy, MdStall, MdDone
  );

  modport slave (
    input  StartE, OpE, SrcAE, SrcBE, HiLoUseD, MdOpD, HiWrW, LoWrW, WdW,
    output Hi, Lo, MdBusy, MdStall, MdDone
  );

endinterface

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate. Used both to take the magnitude of
// signed operands and to re-apply the sign to results. The magnitude of the
// most-negative value comes out as the unsigned 2^(WIDTH-1), which is what
// the iterative datapath expects.
module muldiv_signfix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] val_o
);

  // Negate when requested, pass through otherwise.
  always_comb val_o = neg_i ? ('0 - val_i) : val_i;

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide sequencer owning the HI/LO pair.
// Radix-2 shift/add multiply and restoring divide on operand magnitudes,
// signs re-applied in a single FIX cycle. MdStall holds Decode while busy.
// Build option MULDIV_FAST_MUL_EN: MULT/MULTU use a single-cycle product and
// skip RUN (IDLE -> FIX); divides stay iterative. Ports are the same either way.
//
// state   | meaning
// IDLE    | waiting for StartE; Hi/Lo only change via W-stage writes
// RUN     | one multiplier/quotient bit per cycle, count_q counts down to 0
// FIX     | apply result signs, write Hi/Lo, pulse MdDone
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  muldiv_sequencer_if.slave md
);

  localparam int CW = $clog2(WIDTH);

  md_state_e        state_q;
  logic [CW-1:0]    count_q;
  md_op_e           op_q;
  logic             res_neg_q;
  logic             rem_neg_q;
  logic             div0_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] low_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;

  logic             stall;
  logic             accept;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ok;
  logic [WIDTH-1:0] div_sub;

  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quo_fixed;
  logic [WIDTH-1:0]   rem_fixed;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Stall Decode whenever it needs HI/LO or another mul/div while we are busy.
  always_comb stall = busy_q & (md.HiLoUseD | md.MdOpD);

  // Accept only from IDLE; operand signs matter only for the signed ops.
  always_comb begin
    accept = md.StartE & (state_q == ST_IDLE) & ~stall;
    a_neg  = op_is_signed(md.OpE) & md.SrcAE[WIDTH-1];
    b_neg  = op_is_signed(md.OpE) & md.SrcBE[WIDTH-1];
  end

  muldiv_signfix #(.WIDTH(WIDTH)) u_abs_a (.val_i(md.SrcAE), .neg_i(a_neg), .val_o(abs_a));
  muldiv_signfix #(.WIDTH(WIDTH)) u_abs_b (.val_i(md.SrcBE), .neg_i(b_neg), .val_o(abs_b));

  // One iteration of each datapath; the FSM picks which one to commit.
  always_comb begin
    mul_sum   = low_q[0] ? ({1'b0, acc_q} + {1'b0, opb_q}) : {1'b0, acc_q};
    div_shift = {acc_q, low_q[WIDTH-1]};
    div_ok    = (div_shift >= {1'b0, opb_q});
    div_sub   = div_shift[WIDTH-1:0] - opb_q;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;

  // Single-cycle magnitude product, captured straight into {acc,low} on accept.
  always_comb fast_prod = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
`endif

  muldiv_signfix #(.WIDTH(2*WIDTH)) u_fix_prod (
    .val_i({acc_q, low_q}), .neg_i(res_neg_q), .val_o(prod_fixed)
  );
  muldiv_signfix #(.WIDTH(WIDTH)) u_fix_quo (.val_i(low_q), .neg_i(res_neg_q), .val_o(quo_fixed));
  muldiv_signfix #(.WIDTH(WIDTH)) u_fix_rem (.val_i(acc_q), .neg_i(rem_neg_q), .val_o(rem_fixed));

  // Final Hi/Lo values. A zero divisor leaves the dividend magnitude in the
  // remainder, so re-signing it restores the original dividend for Hi.
  always_comb begin
    if (op_is_div(op_q)) begin
      fix_hi = rem_fixed;
      fix_lo = div0_q ? DIV0_LO[WIDTH-1:0] : quo_fixed;
    end else begin
      fix_hi = prod_fixed[2*WIDTH-1:WIDTH];
      fix_lo = prod_fixed[WIDTH-1:0];
    end
  end

  // Sequencer FSM with its counter, datapath registers and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      op_q      <= OP_MULT;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      acc_q     <= '0;
      low_q     <= '0;
      opb_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q      <= md_op_e'(md.OpE);
            res_neg_q <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            div0_q    <= (md.SrcBE == '0);
            count_q   <= CW'(WIDTH - 1);
            opb_q     <= abs_b;
            busy_q    <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
            if (!op_is_div(md.OpE)) begin
              {acc_q, low_q} <= fast_prod;
              state_q        <= ST_FIX;
              done_q         <= 1'b1;
            end else begin
              acc_q   <= '0;
              low_q   <= abs_a;
              state_q <= ST_RUN;
            end
`else
            acc_q   <= '0;
            low_q   <= abs_a;
            state_q <= ST_RUN;
`endif
          end
        end
        ST_RUN: begin
          if (op_is_div(op_q)) begin
            acc_q <= div_ok ? div_sub : div_shift[WIDTH-1:0];
            low_q <= {low_q[WIDTH-2:0], div_ok};
          end else begin
            acc_q <= mul_sum[WIDTH:1];
            low_q <= {mul_sum[0], low_q[WIDTH-1:1]};
          end
          if (count_q == '0) begin
            state_q <= ST_FIX;
            done_q  <= 1'b1;
          end else begin
            count_q <= count_q - 1'b1;
          end
        end
        ST_FIX: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // HI/LO: sequencer result at FIX, W-stage MTHI/MTLO override it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (state_q == ST_FIX) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end
      if (md.HiWrW) hi_q <= md.WdW;
      if (md.LoWrW) lo_q <= md.WdW;
    end
  end

  // Drive the interface outputs from registers (MdStall also needs D inputs).
  always_comb begin
    md.Hi      = hi_q;
    md.Lo      = lo_q;
    md.MdBusy  = busy_q;
    md.MdDone  = done_q;
    md.MdStall = stall;
  end

endmodule
